// File: rtl/ram_pkg.sv
// Shared types and helpers for the multi-read, single-write RAM.
// merge_lanes works on a fixed maximum width; callers cast in and out.
package ram_pkg;

   typedef enum logic [0:0] {
      CLEAR = 1'b0,
      READY = 1'b1
   } ram_state_e;

   localparam int unsigned max_width_lp = 256;

   function automatic int lanes(input int width, input int lane_width);
      return width / lane_width;
   endfunction

   // Bit i takes new_word when the lane holding bit i is enabled in mask.
   function automatic logic [max_width_lp-1:0] merge_lanes(
      input logic [max_width_lp-1:0] old_word,
      input logic [max_width_lp-1:0] new_word,
      input logic [max_width_lp-1:0] mask,
      input int                      lane_width
   );
      logic [max_width_lp-1:0] res;
      for (int i = 0; i < max_width_lp; i++) begin
         res[i] = mask[i / lane_width] ? new_word[i] : old_word[i];
      end
      return res;
   endfunction

endpackage

// File: rtl/ram_clear_ctrl.sv
// Post-reset zero-fill sequencer: walks every address once, then raises ready.
// The top level steers clr_addr_o/clr_en_o onto the single write port.
module ram_clear_ctrl
   import ram_pkg::*;
#(
   parameter int depth_p          = 32,
   parameter bit clear_on_reset_p = 1'b1,
   parameter int addr_width_p     = $clog2(depth_p)
) (
   input  logic                    clk_i,
   input  logic                    reset_i,
   output logic                    ready_o,
   output logic                    clr_en_o,
   output logic [addr_width_p-1:0] clr_addr_o
);

   localparam ram_state_e              reset_state_lp = clear_on_reset_p ? CLEAR : READY;
   localparam logic [addr_width_p-1:0] last_addr_lp   = addr_width_p'(depth_p - 1);

   ram_state_e              state_r;
   ram_state_e              state_next_s;
   logic [addr_width_p-1:0] cnt_r;
   logic [addr_width_p-1:0] cnt_next_s;
   logic                    ready_r;
   logic                    clr_en_s;

   // State, sweep counter and registered ready flag.
   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         state_r <= reset_state_lp;
         cnt_r   <= '0;
         ready_r <= 1'b0;
      end else begin
         state_r <= state_next_s;
         cnt_r   <= cnt_next_s;
         ready_r <= (state_next_s == READY);
      end
   end

   // Next state; the sweep write is held off while reset is asserted.
   always_comb begin
      state_next_s = state_r;
      cnt_next_s   = cnt_r;
      clr_en_s     = 1'b0;
      case (state_r)
         CLEAR: begin
            clr_en_s   = ~reset_i;
            cnt_next_s = cnt_r + addr_width_p'(1);
            if (cnt_r == last_addr_lp) begin
               state_next_s = READY;
            end else begin
               state_next_s = CLEAR;
            end
         end
         READY: begin
            state_next_s = READY;
         end
         default: begin
            state_next_s = reset_state_lp;
         end
      endcase
   end

   assign ready_o    = ready_r;
   assign clr_en_o   = clr_en_s;
   assign clr_addr_o = cnt_r;

endmodule

// File: rtl/ram_nr1w_sync.sv
// Multi-read-port, single-write-port RAM with byte-lane write masks,
// registered reads, optional write-to-read bypass and post-reset zero sweep.
module ram_nr1w_sync
   import ram_pkg::*;
#(
   parameter int    width_p          = 8,
   parameter int    depth_p          = 32,
   parameter int    rd_ports_p       = 2,
   parameter int    lane_width_p     = 8,
   parameter bit    bypass_p         = 1'b1,
   parameter bit    clear_on_reset_p = 1'b1,
   parameter string filename_p       = ""
) (
   input  logic                                  clk_i,
   input  logic                                  reset_i,
   output logic                                  ready_o,
   input  logic                                  wr_valid_i,
   input  logic [$clog2(depth_p)-1:0]            wr_addr_i,
   input  logic [width_p-1:0]                    wr_data_i,
   input  logic [width_p/lane_width_p-1:0]       wr_mask_i,
   input  logic [rd_ports_p-1:0]                 rd_valid_i,
   input  logic [rd_ports_p*$clog2(depth_p)-1:0] rd_addr_i,
   output logic [rd_ports_p-1:0]                 rd_valid_o,
   output logic [rd_ports_p*width_p-1:0]         rd_data_o
);

   localparam int             addr_w_lp   = $clog2(depth_p);
   localparam int             mask_w_lp   = lanes(width_p, lane_width_p);
   localparam logic [addr_w_lp:0] depth_lp = (addr_w_lp + 1)'(depth_p);
   localparam bit             init_file_lp = (filename_p != "") && !clear_on_reset_p;

   logic [width_p-1:0]   mem_r [depth_p];
   logic                 ready_s;
   logic                 clr_en_s;
   logic [addr_w_lp-1:0] clr_addr_s;
   logic                 user_we_s;
   logic                 we_s;
   logic [addr_w_lp-1:0] waddr_s;
   logic [width_p-1:0]   wdata_s;
   logic [mask_w_lp-1:0] wmask_s;
   logic [width_p-1:0]   wword_s;

   ram_clear_ctrl #(
      .depth_p         (depth_p),
      .clear_on_reset_p(clear_on_reset_p),
      .addr_width_p    (addr_w_lp)
   ) u_clear_ctrl (
      .clk_i     (clk_i),
      .reset_i   (reset_i),
      .ready_o   (ready_s),
      .clr_en_o  (clr_en_s),
      .clr_addr_o(clr_addr_s)
   );

   // Preloaded contents are left to the simulation environment when enabled.
   if (init_file_lp) begin : g_init_file
   end

   assign user_we_s = ready_s & wr_valid_i & ({1'b0, wr_addr_i} < depth_lp);

   // The sweep owns the write port until the array is ready.
   always_comb begin
      if (clr_en_s) begin
         we_s    = 1'b1;
         waddr_s = clr_addr_s;
         wdata_s = '0;
         wmask_s = '1;
      end else begin
         we_s    = user_we_s;
         waddr_s = wr_addr_i;
         wdata_s = wr_data_i;
         wmask_s = wr_mask_i;
      end
   end

   assign wword_s = width_p'(merge_lanes(max_width_lp'(mem_r[waddr_s]),
                                         max_width_lp'(wdata_s),
                                         max_width_lp'(wmask_s),
                                         lane_width_p));

   // Storage array; contents survive reset.
   always_ff @(posedge clk_i) begin
      if (we_s) begin
         mem_r[waddr_s] <= wword_s;
      end
   end

   for (genvar p = 0; p < rd_ports_p; p++) begin : g_rd
      logic [addr_w_lp-1:0] raddr_s;
      logic                 hit_s;
      logic [width_p-1:0]   rword_s;
      logic [width_p-1:0]   rdata_r;
      logic                 rvalid_r;

      assign raddr_s = rd_addr_i[p*addr_w_lp +: addr_w_lp];
      assign hit_s   = (bypass_p == 1'b1) && user_we_s && (wr_addr_i == raddr_s);

      // Word presented to this port: zero when out of range, merged on a bypass hit.
      always_comb begin
         if ({1'b0, raddr_s} >= depth_lp) begin
            rword_s = '0;
         end else if (hit_s) begin
            rword_s = width_p'(merge_lanes(max_width_lp'(mem_r[raddr_s]),
                                           max_width_lp'(wr_data_i),
                                           max_width_lp'(wr_mask_i),
                                           lane_width_p));
         end else begin
            rword_s = mem_r[raddr_s];
         end
      end

      // Registered read; data holds when the port is idle.
      always_ff @(posedge clk_i or posedge reset_i) begin
         if (reset_i) begin
            rvalid_r <= 1'b0;
            rdata_r  <= '0;
         end else if (ready_s) begin
            rvalid_r <= rd_valid_i[p];
            if (rd_valid_i[p]) begin
               rdata_r <= rword_s;
            end
         end else begin
            rvalid_r <= 1'b0;
         end
      end

      assign rd_valid_o[p]                   = rvalid_r;
      assign rd_data_o[p*width_p +: width_p] = rdata_r;
   end

   assign ready_o = ready_s;

endmodule

// File: tb/tb_ram_nr1w_sync.sv
// Bench with two instances: A (depth 20, bypass on) and B (depth 32, bypass off),
// driven by shared stimulus and checked against a reference model via a queue.
module tb_ram_nr1w_sync;

   typedef struct {
      int          dut;
      int          port;
      logic        valid;
      logic [31:0] data;
   } exp_t;

   logic        clk;
   logic        reset;
   logic        wr_valid;
   logic [4:0]  wr_addr;
   logic [31:0] wr_data;
   logic [3:0]  wr_mask;
   logic [2:0]  rd_valid;
   logic [14:0] rd_addr;
   logic        ready_a, ready_b;
   logic [2:0]  rd_valid_a, rd_valid_b;
   logic [95:0] rd_data_a, rd_data_b;

   logic [31:0] mem_a [20];
   logic [31:0] mem_b [32];
   logic [31:0] last_a [3];
   logic [31:0] last_b [3];
   exp_t        sb_q[$];
   int          n_checks = 0;
   int          n_errors = 0;

   ram_nr1w_sync #(.width_p(32), .depth_p(20), .rd_ports_p(3), .lane_width_p(8),
                   .bypass_p(1'b1), .clear_on_reset_p(1'b1)) dut_a (
      .clk_i(clk), .reset_i(reset), .ready_o(ready_a),
      .wr_valid_i(wr_valid), .wr_addr_i(wr_addr), .wr_data_i(wr_data), .wr_mask_i(wr_mask),
      .rd_valid_i(rd_valid), .rd_addr_i(rd_addr), .rd_valid_o(rd_valid_a), .rd_data_o(rd_data_a));

   ram_nr1w_sync #(.width_p(32), .depth_p(32), .rd_ports_p(3), .lane_width_p(8),
                   .bypass_p(1'b0), .clear_on_reset_p(1'b1)) dut_b (
      .clk_i(clk), .reset_i(reset), .ready_o(ready_b),
      .wr_valid_i(wr_valid), .wr_addr_i(wr_addr), .wr_data_i(wr_data), .wr_mask_i(wr_mask),
      .rd_valid_i(rd_valid), .rd_addr_i(rd_addr), .rd_valid_o(rd_valid_b), .rd_data_o(rd_data_b));

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   function automatic logic [31:0] mrg(input logic [31:0] o, input logic [31:0] n, input logic [3:0] m);
      logic [31:0] r;
      for (int l = 0; l < 4; l++) r[l*8 +: 8] = m[l] ? n[l*8 +: 8] : o[l*8 +: 8];
      return r;
   endfunction

   task automatic model_zero();
      for (int i = 0; i < 20; i++) mem_a[i] = 32'h0;
      for (int i = 0; i < 32; i++) mem_b[i] = 32'h0;
      for (int p = 0; p < 3; p++) begin
         last_a[p] = 32'h0;
         last_b[p] = 32'h0;
      end
   endtask

   // One clock of stimulus: predict, push, clock, pop and compare.
   task automatic do_cycle(input logic wv, input logic [4:0] wa, input logic [31:0] wd,
                           input logic [3:0] wm, input logic [2:0] rv,
                           input logic [4:0] a0, input logic [4:0] a1, input logic [4:0] a2);
      logic [4:0]  ra [3];
      logic [31:0] v;
      exp_t        e;
      logic        act_v;
      logic [31:0] act_d;
      ra[0] = a0; ra[1] = a1; ra[2] = a2;
      wr_valid = wv; wr_addr = wa; wr_data = wd; wr_mask = wm;
      rd_valid = rv; rd_addr = {a2, a1, a0};
      for (int p = 0; p < 3; p++) begin
         if (rv[p]) begin
            v = (ra[p] < 5'd20) ? mem_a[ra[p]] : 32'h0;
            if (wv && (wa < 5'd20) && (wa == ra[p])) v = mrg(v, wd, wm);
            last_a[p] = v;
            last_b[p] = mem_b[ra[p]];
         end
         sb_q.push_back('{0, p, rv[p], last_a[p]});
         sb_q.push_back('{1, p, rv[p], last_b[p]});
      end
      if (wv) begin
         if (wa < 5'd20) mem_a[wa] = mrg(mem_a[wa], wd, wm);
         mem_b[wa] = mrg(mem_b[wa], wd, wm);
      end
      @(posedge clk);
      #1;
      while (sb_q.size() > 0) begin
         e = sb_q.pop_front();
         act_v = (e.dut == 0) ? rd_valid_a[e.port] : rd_valid_b[e.port];
         act_d = (e.dut == 0) ? rd_data_a[e.port*32 +: 32] : rd_data_b[e.port*32 +: 32];
         n_checks++;
         if (act_v !== e.valid || act_d !== e.data) begin
            n_errors++;
            $display("FAIL rd dut%0d port%0d: got v=%b d=%h, expected v=%b d=%h",
                     e.dut, e.port, act_v, act_d, e.valid, e.data);
         end
      end
   endtask

   // Release reset and check the ready rise times and gated reads during the sweep.
   task automatic check_sweep(input logic hold_req);
      wr_valid = hold_req; wr_addr = 5'd25; wr_data = 32'hFFFF_FFFF; wr_mask = 4'hF;
      rd_valid = hold_req ? 3'b111 : 3'b000; rd_addr = 15'h0;
      @(negedge clk);
      reset = 1'b0;
      for (int c = 1; c <= 34; c++) begin
         @(posedge clk);
         #1;
         n_checks++;
         if (ready_a !== (c >= 20) || ready_b !== (c >= 32)) begin
            n_errors++;
            $display("FAIL sweep_ready c=%0d: got a=%b b=%b, expected a=%b b=%b",
                     c, ready_a, ready_b, c >= 20, c >= 32);
         end
         if (hold_req) begin
            n_checks++;
            if (rd_valid_a !== ((c >= 21) ? 3'b111 : 3'b000) ||
                rd_valid_b !== ((c >= 33) ? 3'b111 : 3'b000)) begin
               n_errors++;
               $display("FAIL sweep_rdvalid c=%0d: got a=%b b=%b", c, rd_valid_a, rd_valid_b);
            end
         end
         if (c == 31) wr_valid = 1'b0;
      end
      rd_valid = 3'b000;
      model_zero();
   endtask

   task automatic test_reset();
      reset = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      n_checks++;
      if (ready_a !== 1'b0 || ready_b !== 1'b0) begin
         n_errors++;
         $display("FAIL reset_ready: got a=%b b=%b, expected 0", ready_a, ready_b);
      end
      n_checks++;
      if (rd_valid_a !== 3'b000 || rd_valid_b !== 3'b000 || rd_data_a !== 96'h0 || rd_data_b !== 96'h0) begin
         n_errors++;
         $display("FAIL reset_rd: got va=%b vb=%b da=%h db=%h, expected zeros",
                  rd_valid_a, rd_valid_b, rd_data_a, rd_data_b);
      end
      check_sweep(1'b1);
   endtask

   task automatic test_clear();
      for (int i = 0; i < 32; i++) begin
         do_cycle(1'b0, 5'd0, 32'h0, 4'h0, 3'b111, 5'(i), 5'((i + 1) % 32), 5'((i + 2) % 32));
      end
   endtask

   task automatic test_mask_merge();
      do_cycle(1'b1, 5'd5, 32'hAABB_CCDD, 4'b1111, 3'b000, 5'd0, 5'd0, 5'd0);
      do_cycle(1'b1, 5'd5, 32'h1122_3344, 4'b0101, 3'b000, 5'd0, 5'd0, 5'd0);
      do_cycle(1'b0, 5'd0, 32'h0, 4'h0, 3'b001, 5'd5, 5'd0, 5'd0);
      n_checks++;
      if (rd_data_a[31:0] !== 32'hAA22_CC44) begin
         n_errors++;
         $display("FAIL mask_merge: got %h, expected aa22cc44", rd_data_a[31:0]);
      end
      do_cycle(1'b1, 5'd6, 32'h5555_5555, 4'b0000, 3'b010, 5'd0, 5'd6, 5'd0);
   endtask

   task automatic test_bypass();
      do_cycle(1'b1, 5'd3, 32'h1234_5678, 4'b1111, 3'b000, 5'd0, 5'd0, 5'd0);
      do_cycle(1'b1, 5'd3, 32'hFFFF_FFFF, 4'b0011, 3'b001, 5'd3, 5'd0, 5'd0);
      n_checks++;
      if (rd_data_a[31:0] !== 32'h1234_FFFF || rd_data_b[31:0] !== 32'h1234_5678) begin
         n_errors++;
         $display("FAIL bypass: got a=%h b=%h, expected a=1234ffff b=12345678",
                  rd_data_a[31:0], rd_data_b[31:0]);
      end
      do_cycle(1'b0, 5'd0, 32'h0, 4'h0, 3'b111, 5'd3, 5'd3, 5'd3);
   endtask

   task automatic test_multiport();
      do_cycle(1'b1, 5'd7, 32'h0707_0707, 4'hF, 3'b000, 5'd0, 5'd0, 5'd0);
      do_cycle(1'b1, 5'd9, 32'h0909_0909, 4'hF, 3'b111, 5'd5, 5'd5, 5'd5);
      do_cycle(1'b0, 5'd0, 32'h0, 4'h0, 3'b101, 5'd7, 5'd7, 5'd9);
      n_checks++;
      if (rd_valid_a !== 3'b101 || rd_data_a[63:32] !== 32'hAA22_CC44) begin
         n_errors++;
         $display("FAIL multiport: got v=%b p1=%h, expected v=101 p1=aa22cc44",
                  rd_valid_a, rd_data_a[63:32]);
      end
   endtask

   task automatic test_out_of_range();
      do_cycle(1'b1, 5'd25, 32'hDEAD_BEEF, 4'hF, 3'b000, 5'd0, 5'd0, 5'd0);
      do_cycle(1'b0, 5'd0, 32'h0, 4'h0, 3'b111, 5'd25, 5'd19, 5'd5);
      n_checks++;
      if (rd_valid_a[0] !== 1'b1 || rd_data_a[31:0] !== 32'h0) begin
         n_errors++;
         $display("FAIL oor_read: got v=%b d=%h, expected v=1 d=0", rd_valid_a[0], rd_data_a[31:0]);
      end
      for (int i = 0; i < 20; i += 3) begin
         do_cycle(1'b0, 5'd0, 32'h0, 4'h0, 3'b111, 5'(i), 5'(i + 1), 5'(i + 2));
      end
   endtask

   task automatic test_back_to_back();
      logic [4:0] wa;
      for (int i = 0; i < 60; i++) begin
         wa = 5'($urandom_range(0, 24));
         do_cycle(1'($urandom_range(0, 1)), wa, $urandom, 4'($urandom_range(0, 15)),
                  3'($urandom_range(0, 7)),
                  (i % 3 == 0) ? wa : 5'($urandom_range(0, 24)),
                  (i % 2 == 0) ? wa : 5'($urandom_range(0, 24)),
                  5'($urandom_range(0, 24)));
      end
   endtask

   task automatic test_reset_mid_sweep();
      do_cycle(1'b0, 5'd0, 32'h0, 4'h0, 3'b111, 5'd1, 5'd2, 5'd3);
      reset = 1'b1;
      #2;
      n_checks++;
      if (ready_a !== 1'b0 || ready_b !== 1'b0 || rd_valid_a !== 3'b000 ||
          rd_valid_b !== 3'b000 || rd_data_a !== 96'h0) begin
         n_errors++;
         $display("FAIL async_reset: got ra=%b rb=%b va=%b vb=%b", ready_a, ready_b, rd_valid_a, rd_valid_b);
      end
      @(negedge clk);
      reset = 1'b0;
      repeat (10) @(posedge clk);
      #1;
      reset = 1'b1;
      #1;
      n_checks++;
      if (ready_a !== 1'b0 || rd_valid_a !== 3'b000) begin
         n_errors++;
         $display("FAIL mid_sweep_reset: got ready=%b v=%b, expected 0", ready_a, rd_valid_a);
      end
      repeat (2) @(posedge clk);
      check_sweep(1'b0);
      test_clear();
   endtask

   initial begin
      clk = 1'b0; reset = 1'b1;
      wr_valid = 1'b0; wr_addr = 5'd0; wr_data = 32'h0; wr_mask = 4'h0;
      rd_valid = 3'b000; rd_addr = 15'h0;
      model_zero();
      test_reset();
      test_clear();
      test_mask_merge();
      test_bypass();
      test_multiport();
      test_out_of_range();
      test_back_to_back();
      test_reset_mid_sweep();
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
